// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port backing memory between the instruction-fetch
// and data ports, with data priority, an anti-starvation streak limit and an ack timeout.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ready_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic [31:0] dm_rdata_o,
    output logic        dm_ready_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic        stall_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;
    state_t     state, state_nx;
    logic [2:0] streak;
    logic [7:0] wait_cnt;
    logic       gnt_dm, we_q, busy, timeout, grant_dm, grant_if;

    assign busy     = (state == BUSY_IF) || (state == BUSY_DM);
    // ack wins over a timeout landing in the same cycle
    assign timeout  = busy && !mem_ack_i && (wait_cnt == 8'(TIMEOUT - 1));
    assign grant_dm = dm_req_i && (!if_req_i || streak != 3'(STARVE_LIMIT));
    assign grant_if = if_req_i && !grant_dm;

    assign mem_we_o   = busy && we_q;
    assign if_ready_o = (state == DONE) && !gnt_dm;
    assign dm_ready_o = (state == DONE) && gnt_dm;
    assign stall_o    = (if_req_i && !if_ready_o) || (dm_req_i && !dm_ready_o);

    always_comb begin
        state_nx = IDLE;
        if (state == IDLE) state_nx = grant_dm ? BUSY_DM : (grant_if ? BUSY_IF : IDLE);
        else if (busy) state_nx = (mem_ack_i || timeout) ? DONE : state;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            we_q        <= 1'b0;
            gnt_dm      <= 1'b0;
            streak      <= '0;
            wait_cnt    <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_req_o <= (state_nx == BUSY_IF) || (state_nx == BUSY_DM);
            if (state == IDLE && (grant_dm || grant_if)) begin
                gnt_dm     <= grant_dm;
                mem_addr_o <= grant_dm ? dm_addr_i : if_addr_i;
                we_q       <= grant_dm && dm_we_i;
                streak     <= (grant_dm && if_req_i) ? streak + 3'd1 : 3'd0;
                wait_cnt   <= '0;
                if (grant_dm) mem_wdata_o <= dm_wdata_i;
            end
            if (busy && !mem_ack_i) wait_cnt <= wait_cnt + 8'd1;
            if (busy && (mem_ack_i || timeout)) begin
                if (state == BUSY_IF) if_rdata_o <= timeout ? '0 : mem_rdata_i;
                else if (timeout || !we_q) dm_rdata_o <= timeout ? '0 : mem_rdata_i;
            end
            if (timeout) err_o <= 1'b1;
        end
    end
endmodule
